param_sim_ram: RTL and testbench

PARAM_SIM_RAM -- requirements
Module: param_sim_ram

---
 rtl/param_sim_ram_if.sv | 32 +++
 rtl/param_sim_ram.sv | 162 ++++++++++++++++
 tb/tb_param_sim_ram.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/param_sim_ram_if.sv
`default_nettype none
// ============================================================================
//  Module   : param_sim_ram_if
//  Brief    : Write, read and clear bus for param_sim_ram (flat packed ports)
//  Revision : 1.0 - initial release
// ============================================================================
interface param_sim_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int NUM_READ   = 2
);
    logic                           clear;
    logic                           busy;
    logic [ADDR_WIDTH-1:0]          waddr;
    logic [DATA_WIDTH/8-1:0]        wstrb;
    logic [DATA_WIDTH-1:0]          wdata;
    logic [NUM_READ-1:0]            ren;
    logic [NUM_READ*ADDR_WIDTH-1:0] raddr;
    logic [NUM_READ*DATA_WIDTH-1:0] rdata;
    logic [NUM_READ-1:0]            rvalid;

    modport master (
        output clear, waddr, wstrb, wdata, ren, raddr,
        input  busy, rdata, rvalid
    );

    modport slave (
        input  clear, waddr, wstrb, wdata, ren, raddr,
        output busy, rdata, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/param_sim_ram.sv
`default_nettype none
// ============================================================================
//  Module   : param_sim_ram
//  Brief    : Byte-strobed RAM with N read ports, self-clearing after reset
//  Revision : 1.0 - initial release
// ============================================================================
module param_sim_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8192,
    parameter int NUM_READ     = 2,
    parameter int READ_LATENCY = 1,
    parameter int BYPASS       = 1
) (
    input  wire logic      clock,
    input  wire logic      reset,
    param_sim_ram_if.slave bus
);
    localparam int c_ADDR_WIDTH = $clog2(DEPTH);
    localparam int c_NUM_LANES  = DATA_WIDTH / 8;

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_IDLE  = 1'b1;

    localparam logic [c_ADDR_WIDTH-1:0] c_CNT_LAST = {c_ADDR_WIDTH{1'b1}};
    localparam logic [c_ADDR_WIDTH-1:0] c_CNT_ONE  = {{(c_ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]                     r_state;
    logic [0:0]                     w_state_nxt;
    logic [c_ADDR_WIDTH-1:0]        r_cnt;
    logic                           w_busy;
    logic                           w_clr_we;
    logic                           w_clr_start;
    logic                           w_wr_en;
    logic [NUM_READ-1:0]            w_rd_acc;
    logic [NUM_READ-1:0]            w_rvalid;
    logic [NUM_READ*DATA_WIDTH-1:0] w_rdata;

    // Array has no reset; the clear sequence after reset zeroes it
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_CLEAR: if (r_cnt == c_CNT_LAST) w_state_nxt = c_ST_IDLE;
            default:    if (bus.clear)           w_state_nxt = c_ST_CLEAR;
        endcase
    end

    // Clear has priority over a same-cycle write; reads are only taken in IDLE
    always_comb begin
        w_busy      = 1'b0;
        w_clr_we    = 1'b0;
        w_clr_start = 1'b0;
        w_wr_en     = 1'b0;
        w_rd_acc    = '0;
        case (r_state)
            c_ST_CLEAR: begin
                w_busy   = 1'b1;
                w_clr_we = 1'b1;
            end
            default: begin
                w_clr_start = bus.clear;
                w_wr_en     = !bus.clear && (|bus.wstrb);
                w_rd_acc    = bus.ren;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_clr_start) begin
            r_cnt <= '0;
        end else if (w_clr_we) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < c_NUM_LANES; i++) begin
                if (bus.wstrb[i]) begin
                    r_mem[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
            logic [c_ADDR_WIDTH-1:0] w_ra;
            logic [DATA_WIDTH-1:0]   w_rd_word;
            logic                    r_s1_valid;
            logic [DATA_WIDTH-1:0]   r_s1_data;

            assign w_ra = bus.raddr[p*c_ADDR_WIDTH +: c_ADDR_WIDTH];

            // Merge the same-edge write into the returned word when bypassing
            always_comb begin
                w_rd_word = r_mem[w_ra];
                if ((BYPASS != 0) && w_wr_en && (bus.waddr == w_ra)) begin
                    for (int i = 0; i < c_NUM_LANES; i++) begin
                        if (bus.wstrb[i]) begin
                            w_rd_word[8*i +: 8] = bus.wdata[8*i +: 8];
                        end
                    end
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= '0;
                end else begin
                    r_s1_valid <= w_rd_acc[p];
                    if (w_rd_acc[p]) begin
                        r_s1_data <= w_rd_word;
                    end
                end
            end

            if (READ_LATENCY == 2) begin : g_lat2
                logic                  r_s2_valid;
                logic [DATA_WIDTH-1:0] r_s2_data;

                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) begin
                        r_s2_valid <= 1'b0;
                        r_s2_data  <= '0;
                    end else begin
                        r_s2_valid <= r_s1_valid;
                        if (r_s1_valid) begin
                            r_s2_data <= r_s1_data;
                        end
                    end
                end

                assign w_rvalid[p]                       = r_s2_valid;
                assign w_rdata[p*DATA_WIDTH +: DATA_WIDTH] = r_s2_data;
            end else begin : g_lat1
                assign w_rvalid[p]                       = r_s1_valid;
                assign w_rdata[p*DATA_WIDTH +: DATA_WIDTH] = r_s1_data;
            end
        end
    endgenerate

    assign bus.busy   = w_busy;
    assign bus.rvalid = w_rvalid;
    assign bus.rdata  = w_rdata;

endmodule
`default_nettype wire

// File: tb/tb_param_sim_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_sim_ram
//  Brief    : Two param_sim_ram variants (lat1/bypass, lat2/no-bypass) vs model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_sim_ram;
    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int NR    = 2;
    localparam int NL    = DW / 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [NL-1:0] wstrb = '0;
    logic [DW-1:0] wdata = '0;
    logic [NR-1:0] ren   = '0;
    logic [NR*AW-1:0] raddr = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    param_sim_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus_a ();
    param_sim_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus_b ();

    assign bus_a.clear = clear;  assign bus_b.clear = clear;
    assign bus_a.waddr = waddr;  assign bus_b.waddr = waddr;
    assign bus_a.wstrb = wstrb;  assign bus_b.wstrb = wstrb;
    assign bus_a.wdata = wdata;  assign bus_b.wdata = wdata;
    assign bus_a.ren   = ren;    assign bus_b.ren   = ren;
    assign bus_a.raddr = raddr;  assign bus_b.raddr = raddr;

    param_sim_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_READ(NR),
                    .READ_LATENCY(1), .BYPASS(1)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    param_sim_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_READ(NR),
                    .READ_LATENCY(2), .BYPASS(0)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    // Reference model: word array, cycles of clearing left, expected outputs
    logic [DW-1:0] mem [DEPTH];
    int            clear_left;
    logic [NR-1:0] exp_va, exp_vb, pend_v;
    logic [DW-1:0] exp_da [NR];
    logic [DW-1:0] exp_db [NR];
    logic [DW-1:0] pend_d [NR];

    logic [DW-1:0] c034_data [5] = '{32'hdeadbeef, 32'h0000beef, 32'hdead0000,
                                     32'h000000ef, 32'h0000be00};
    logic [NL-1:0] c034_strb [5] = '{4'hf, 4'h3, 4'hc, 4'h1, 4'h2};

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        clear_left = DEPTH;
        exp_va = '0;
        exp_vb = '0;
        pend_v = '0;
        for (int p = 0; p < NR; p++) begin
            exp_da[p] = '0;
            exp_db[p] = '0;
            pend_d[p] = '0;
        end
    endtask

    task automatic model_edge();
        logic          wr_ok;
        logic [AW-1:0] a;
        logic [DW-1:0] oldw, neww;
        logic [NR-1:0] v;
        wr_ok = (clear_left == 0) && !clear && (wstrb != '0);
        exp_vb = pend_v;
        for (int p = 0; p < NR; p++) begin
            a    = raddr[p*AW +: AW];
            v[p] = (clear_left == 0) && ren[p];
            oldw = mem[a];
            neww = oldw;
            if (wr_ok && waddr == a)
                for (int i = 0; i < NL; i++)
                    if (wstrb[i]) neww[8*i +: 8] = wdata[8*i +: 8];
            if (v[p]) exp_da[p] = neww;
            if (pend_v[p]) exp_db[p] = pend_d[p];
            pend_d[p] = oldw;
        end
        exp_va = v;
        pend_v = v;
        if (clear_left > 0) begin
            mem[DEPTH - clear_left] = '0;
            clear_left--;
        end else if (clear) begin
            clear_left = DEPTH;
        end else if (wr_ok) begin
            for (int i = 0; i < NL; i++)
                if (wstrb[i]) mem[waddr][8*i +: 8] = wdata[8*i +: 8];
        end
    endtask

    task automatic check_all();
        chk("a.busy", DW'(bus_a.busy), DW'(clear_left > 0));
        chk("b.busy", DW'(bus_b.busy), DW'(clear_left > 0));
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("a.rvalid%0d", p), DW'(bus_a.rvalid[p]), DW'(exp_va[p]));
            chk($sformatf("b.rvalid%0d", p), DW'(bus_b.rvalid[p]), DW'(exp_vb[p]));
            chk($sformatf("a.rdata%0d", p), bus_a.rdata[p*DW +: DW], exp_da[p]);
            chk($sformatf("b.rdata%0d", p), bus_b.rdata[p*DW +: DW], exp_db[p]);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        clear = 1'b0;
        wstrb = '0;
        ren   = '0;
    endtask

    task automatic do_reset(input int n);
        idle();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (n) begin
            @(posedge clock);
            #1;
            check_all();
        end
        reset = 1'b1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [NL-1:0] s, input logic [DW-1:0] d);
        waddr = a;
        wstrb = s;
        wdata = d;
        cycle();
        idle();
    endtask

    // One read, then idle so both latencies deliver and rdata must hold
    task automatic rd_hold(input int port, input logic [AW-1:0] a, input logic [DW-1:0] ea,
                           input logic [DW-1:0] eb, input string tag);
        idle();
        ren[port] = 1'b1;
        raddr[port*AW +: AW] = a;
        cycle();
        idle();
        repeat (3) cycle();
        chk({tag, ".a"}, bus_a.rdata[port*DW +: DW], ea);
        chk({tag, ".b"}, bus_b.rdata[port*DW +: DW], eb);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);
        repeat (DEPTH + 2) cycle();
        rd_hold(0, 8'd37, 32'h0, 32'h0, "post_reset_p0");
        rd_hold(1, AW'(DEPTH - 1), 32'h0, 32'h0, "post_reset_p1");

        for (int i = 0; i < 5; i++) wr(AW'(i), c034_strb[i], 32'hdeadbeef);
        for (int i = 0; i < 5; i++)
            rd_hold(i % NR, AW'(i), c034_data[i], c034_data[i], $sformatf("strb_rd%0d", i));

        // Read-during-write on the same edge
        wr(8'd5, 4'hf, 32'h11223344);
        waddr = 8'd5; wstrb = 4'h1; wdata = 32'h000000aa;
        ren = 2'b01; raddr[0 +: AW] = 8'd5;
        cycle();
        idle();
        repeat (3) cycle();
        chk("rdw.a", bus_a.rdata[0 +: DW], 32'h112233aa);
        chk("rdw.b", bus_b.rdata[0 +: DW], 32'h11223344);
        rd_hold(0, 8'd5, 32'h112233aa, 32'h112233aa, "rdw_after");

        // Full-rate reads on both ports
        ren = 2'b11;
        raddr = {8'd1, 8'd0};
        repeat (4) cycle();
        idle();
        repeat (3) cycle();
        chk("b2b.p0", bus_b.rdata[0 +: DW], 32'hdeadbeef);
        chk("b2b.p1", bus_b.rdata[DW +: DW], 32'h0000beef);

        // Clear with a colliding write; traffic during clear must be ignored
        clear = 1'b1; waddr = 8'd6; wstrb = 4'hf; wdata = 32'hcafef00d;
        cycle();
        repeat (DEPTH) begin
            ren = NR'($urandom); raddr = NR*AW'($urandom);
            waddr = AW'($urandom); wstrb = NL'($urandom); wdata = $urandom;
            clear = ($urandom_range(0, 7) == 0);
            cycle();
        end
        idle();
        repeat (2) cycle();
        for (int i = 0; i <= 6; i++) rd_hold(0, AW'(i), 32'h0, 32'h0, $sformatf("clr_rd%0d", i));

        // Randomized traffic on a small address window plus the top word
        repeat (400) begin
            for (int p = 0; p < NR; p++)
                raddr[p*AW +: AW] = ($urandom_range(0, 9) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 15));
            ren   = NR'($urandom);
            waddr = ($urandom_range(0, 9) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 15));
            wstrb = NL'($urandom);
            wdata = $urandom;
            clear = ($urandom_range(0, 199) == 0);
            cycle();
        end
        idle();
        repeat (DEPTH + 2) cycle();

        // Reset with reads in flight, then reset again 100 words into the clear
        ren = 2'b11;
        raddr = {8'd1, 8'd0};
        cycle();
        do_reset(2);
        repeat (100) cycle();
        do_reset(3);
        repeat (DEPTH + 2) cycle();
        rd_hold(1, 8'd3, 32'h0, 32'h0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
